// File: rtl/btn_press_gen_if.sv
// Command and waveform signals of the button-press generator.
// The bench or controlling logic drives the command side (master); the generator is the slave.
interface btn_press_gen_if #(
    parameter int DUR_W = 16,
    parameter int REP_W = 4
);
    logic             start;
    logic [DUR_W-1:0] dur_ms;
    logic [REP_W-1:0] repeat_n;
    logic             btn_n;
    logic             busy;
    logic             done;

    modport master (
        output start, dur_ms, repeat_n,
        input  btn_n, busy, done
    );

    modport slave (
        input  start, dur_ms, repeat_n,
        output btn_n, busy, done
    );
endinterface

// File: rtl/btn_press_gen.sv
// Generates timed active-low button presses: repeat_n presses of dur_ms each,
// separated by GAP_MS releases, followed by a one-cycle done pulse.
module btn_press_gen #(
    parameter int CLOCK_RATE_HZ = 50_000_000,
    parameter int GAP_MS        = 100,
    parameter int DUR_W         = 16,
    parameter int REP_W         = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_press_gen_if.slave bus
);
    localparam int TPM    = CLOCK_RATE_HZ / 1000;
    localparam int TICK_W = (TPM > 1) ? $clog2(TPM) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TPM - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_MS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [TICK_W-1:0] r_tick;
    logic [DUR_W-1:0]  r_ms;
    logic [DUR_W-1:0]  r_dur;
    logic [REP_W-1:0]  r_rep;
    logic [REP_W-1:0]  r_press;
    logic              r_btn_n;
    logic              r_busy;
    logic              r_done;
    logic              w_btn_n;
    logic              w_busy;
    logic              w_done;
    logic              w_tick;
    logic              w_accept;
    logic              w_press_end;
    logic              w_gap_end;

    assign w_tick      = (r_tick == TICK_LAST);
    assign w_accept    = (r_state == IDLE) && bus.start;
    assign w_press_end = w_tick && (r_ms == (r_dur - DUR_W'(1)));
    assign w_gap_end   = w_tick && (r_ms == GAP_LAST);

    // Outputs are decoded from the next state and registered, so they change on the same edge as the state.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.dur_ms == '0) || (bus.repeat_n == '0)) w_next = FIN;
                    else                                              w_next = PRESS;
                end
            end
            PRESS: begin
                if (w_press_end) w_next = (r_press == r_rep) ? FIN : GAP;
            end
            GAP: begin
                if (w_gap_end) w_next = PRESS;
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_btn_n = (w_next != PRESS);
        w_busy  = (w_next != IDLE);
        w_done  = (w_next == FIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_ms    <= '0;
            r_dur   <= '0;
            r_rep   <= '0;
            r_press <= '0;
            r_btn_n <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_btn_n <= w_btn_n;
            r_busy  <= w_busy;
            r_done  <= w_done;

            // Counters restart on every state change so each phase has an exact length.
            if (w_next != r_state) begin
                r_tick <= '0;
                r_ms   <= '0;
            end else if ((r_state == PRESS) || (r_state == GAP)) begin
                if (w_tick) begin
                    r_tick <= '0;
                    r_ms   <= r_ms + DUR_W'(1);
                end else begin
                    r_tick <= r_tick + TICK_W'(1);
                end
            end

            if (w_accept) begin
                r_dur   <= bus.dur_ms;
                r_rep   <= bus.repeat_n;
                r_press <= REP_W'(1);
            end else if ((r_state == GAP) && (w_next == PRESS)) begin
                r_press <= r_press + REP_W'(1);
            end
        end
    end

    assign bus.btn_n = r_btn_n;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_btn_press_gen.sv
// Bench for btn_press_gen: a waveform-level model expands each accepted command into
// its expected per-cycle {btn_n, busy, done} sequence; scenario tasks compare against it.
module tb_btn_press_gen;
    localparam int CLOCK_RATE_HZ = 4000;
    localparam int GAP_MS        = 2;
    localparam int DUR_W         = 16;
    localparam int REP_W         = 4;
    localparam int TPM           = CLOCK_RATE_HZ / 1000;

    localparam logic [2:0] IDLE_OUT  = 3'b100;
    localparam logic [2:0] PRESS_OUT = 3'b010;
    localparam logic [2:0] GAP_OUT   = 3'b110;
    localparam logic [2:0] FIN_OUT   = 3'b111;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    btn_press_gen_if #(.DUR_W(DUR_W), .REP_W(REP_W)) bus ();

    btn_press_gen #(
        .CLOCK_RATE_HZ(CLOCK_RATE_HZ),
        .GAP_MS       (GAP_MS),
        .DUR_W        (DUR_W),
        .REP_W        (REP_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected outputs for the cycle following each edge.
    logic [2:0] modelQ[$];
    logic [2:0] expOut = IDLE_OUT;
    int         mD;
    int         mR;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            modelQ.delete();
            expOut = IDLE_OUT;
        end else begin
            if (!expOut[1] && (bus.start === 1'b1)) begin
                mD = int'(bus.dur_ms);
                mR = int'(bus.repeat_n);
                if ((mD != 0) && (mR != 0)) begin
                    for (int p = 0; p < mR; p++) begin
                        for (int c = 0; c < mD * TPM; c++) modelQ.push_back(PRESS_OUT);
                        if (p != mR - 1)
                            for (int c = 0; c < GAP_MS * TPM; c++) modelQ.push_back(GAP_OUT);
                    end
                end
                modelQ.push_back(FIN_OUT);
            end
            if (modelQ.size() > 0) expOut = modelQ.pop_front();
            else                   expOut = IDLE_OUT;
        end
    end

    task automatic test_reset();
        logic [2:0] obs;
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.dur_ms = DUR_W'(5);
        bus.repeat_n = REP_W'(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {bus.btn_n, bus.busy, bus.done};
            total++;
            if (obs !== IDLE_OUT) begin
                bad++;
                $display("[TB] FAIL reset.hold cyc=%0d got=%b want=%b", i, obs, IDLE_OUT);
            end
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs = {bus.btn_n, bus.busy, bus.done};
            total++;
            if (obs !== expOut) begin
                bad++;
                $display("[TB] FAIL reset.idle cyc=%0d got=%b want=%b", i, obs, expOut);
            end
        end
    endtask

    task automatic test_single_press();
        logic [2:0] obs;
        int lowCnt = 0, busyCnt = 0, doneCnt = 0, doneAt = -1, firstLow = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dur_ms = DUR_W'(3);
        bus.repeat_n = REP_W'(1);
        for (int rel = 1; rel <= 20; rel++) begin
            @(negedge clk);
            bus.start = 1'b0;
            obs = {bus.btn_n, bus.busy, bus.done};
            total++;
            if (obs !== expOut) begin
                bad++;
                $display("[TB] FAIL single.wave rel=%0d got=%b want=%b", rel, obs, expOut);
            end
            if (obs[2] == 1'b0) begin
                lowCnt++;
                if (firstLow < 0) firstLow = rel;
            end
            if (obs[1]) busyCnt++;
            if (obs[0]) begin
                doneCnt++;
                doneAt = rel;
            end
        end
        total++;
        if (firstLow !== 1) begin bad++; $display("[TB] FAIL single.firstLow got=%0d want=1", firstLow); end
        total++;
        if (lowCnt !== 12) begin bad++; $display("[TB] FAIL single.lowCnt got=%0d want=12", lowCnt); end
        total++;
        if (doneAt !== 13) begin bad++; $display("[TB] FAIL single.doneAt got=%0d want=13", doneAt); end
        total++;
        if (doneCnt !== 1) begin bad++; $display("[TB] FAIL single.doneCnt got=%0d want=1", doneCnt); end
        total++;
        if (busyCnt !== 13) begin bad++; $display("[TB] FAIL single.busyCnt got=%0d want=13", busyCnt); end
    endtask

    task automatic test_repeat();
        logic [2:0] obs;
        logic prevBtn = 1'b1;
        int lowCnt = 0, busyCnt = 0, doneCnt = 0, doneAt = -1, falls = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dur_ms = DUR_W'(1);
        bus.repeat_n = REP_W'(3);
        for (int rel = 1; rel <= 34; rel++) begin
            @(negedge clk);
            bus.start = 1'b0;
            obs = {bus.btn_n, bus.busy, bus.done};
            total++;
            if (obs !== expOut) begin
                bad++;
                $display("[TB] FAIL repeat.wave rel=%0d got=%b want=%b", rel, obs, expOut);
            end
            if (obs[2] == 1'b0) lowCnt++;
            if (prevBtn && (obs[2] == 1'b0)) falls++;
            prevBtn = obs[2];
            if (obs[1]) busyCnt++;
            if (obs[0]) begin
                doneCnt++;
                doneAt = rel;
            end
        end
        total++;
        if (busyCnt !== 29) begin bad++; $display("[TB] FAIL repeat.busyCnt got=%0d want=29", busyCnt); end
        total++;
        if (lowCnt !== 12) begin bad++; $display("[TB] FAIL repeat.lowCnt got=%0d want=12", lowCnt); end
        total++;
        if (falls !== 3) begin bad++; $display("[TB] FAIL repeat.presses got=%0d want=3", falls); end
        total++;
        if (doneAt !== 29) begin bad++; $display("[TB] FAIL repeat.doneAt got=%0d want=29", doneAt); end
        total++;
        if (doneCnt !== 1) begin bad++; $display("[TB] FAIL repeat.doneCnt got=%0d want=1", doneCnt); end
    endtask

    task automatic test_zero_fields();
        logic [2:0] obs;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.dur_ms = (k == 0) ? DUR_W'(0) : DUR_W'(4);
            bus.repeat_n = (k == 0) ? REP_W'(5) : REP_W'(0);
            for (int rel = 1; rel <= 3; rel++) begin
                @(negedge clk);
                bus.start = 1'b0;
                obs = {bus.btn_n, bus.busy, bus.done};
                total++;
                if (obs !== expOut) begin
                    bad++;
                    $display("[TB] FAIL zero.wave case=%0d rel=%0d got=%b want=%b", k, rel, obs, expOut);
                end
                if (rel == 1) begin
                    total++;
                    if (obs !== FIN_OUT) begin
                        bad++;
                        $display("[TB] FAIL zero.fin case=%0d got=%b want=%b", k, obs, FIN_OUT);
                    end
                end
                if (rel == 2) begin
                    total++;
                    if (obs !== IDLE_OUT) begin
                        bad++;
                        $display("[TB] FAIL zero.idle case=%0d got=%b want=%b", k, obs, IDLE_OUT);
                    end
                end
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [2:0] obs;
        int lowCnt = 0, busyCnt = 0, doneCnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dur_ms = DUR_W'(2);
        bus.repeat_n = REP_W'(2);
        for (int rel = 1; rel <= 30; rel++) begin
            @(negedge clk);
            obs = {bus.btn_n, bus.busy, bus.done};
            total++;
            if (obs !== expOut) begin
                bad++;
                $display("[TB] FAIL ignored.wave rel=%0d got=%b want=%b", rel, obs, expOut);
            end
            if (obs[2] == 1'b0) lowCnt++;
            if (obs[1]) busyCnt++;
            if (obs[0]) doneCnt++;
            if ((rel >= 3) && (rel <= 20)) begin
                bus.start = ($urandom_range(0, 1) == 1);
                bus.dur_ms = DUR_W'($urandom_range(0, 65535));
                bus.repeat_n = REP_W'($urandom_range(0, 15));
            end else begin
                bus.start = 1'b0;
            end
        end
        total++;
        if (lowCnt !== 16) begin bad++; $display("[TB] FAIL ignored.lowCnt got=%0d want=16", lowCnt); end
        total++;
        if (busyCnt !== 25) begin bad++; $display("[TB] FAIL ignored.busyCnt got=%0d want=25", busyCnt); end
        total++;
        if (doneCnt !== 1) begin bad++; $display("[TB] FAIL ignored.doneCnt got=%0d want=1", doneCnt); end
    endtask

    task automatic test_reset_mid_press();
        logic [2:0] obs;
        int lowCnt = 0, resetRel = -1, lowCnt2 = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dur_ms = DUR_W'(3);
        bus.repeat_n = REP_W'(2);
        for (int rel = 1; rel <= 12; rel++) begin
            @(negedge clk);
            bus.start = 1'b0;
            obs = {bus.btn_n, bus.busy, bus.done};
            total++;
            if (obs !== expOut) begin
                bad++;
                $display("[TB] FAIL rstmid.wave rel=%0d got=%b want=%b", rel, obs, expOut);
            end
            if ((resetRel > 0) && (rel > resetRel)) begin
                total++;
                if (obs !== IDLE_OUT) begin
                    bad++;
                    $display("[TB] FAIL rstmid.after rel=%0d got=%b want=%b", rel, obs, IDLE_OUT);
                end
            end
            if (obs[2] == 1'b0) lowCnt++;
            if ((lowCnt == 5) && (resetRel < 0)) begin
                rst_n = 1'b0;
                resetRel = rel;
            end else begin
                rst_n = 1'b1;
            end
        end
        rst_n = 1'b1;
        bus.start = 1'b1;
        bus.dur_ms = DUR_W'(3);
        bus.repeat_n = REP_W'(1);
        for (int rel = 1; rel <= 16; rel++) begin
            @(negedge clk);
            bus.start = 1'b0;
            obs = {bus.btn_n, bus.busy, bus.done};
            total++;
            if (obs !== expOut) begin
                bad++;
                $display("[TB] FAIL rstmid.restart rel=%0d got=%b want=%b", rel, obs, expOut);
            end
            if (obs[2] == 1'b0) lowCnt2++;
        end
        total++;
        if (lowCnt2 !== 12) begin bad++; $display("[TB] FAIL rstmid.lowCnt got=%0d want=12", lowCnt2); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] obs;
        logic prevBtn = 1'b1;
        int doneCnt = 0, lastDone = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dur_ms = DUR_W'(1);
        bus.repeat_n = REP_W'(1);
        for (int rel = 1; rel <= 40; rel++) begin
            @(negedge clk);
            obs = {bus.btn_n, bus.busy, bus.done};
            total++;
            if (obs !== expOut) begin
                bad++;
                $display("[TB] FAIL b2b.wave rel=%0d got=%b want=%b", rel, obs, expOut);
            end
            if (prevBtn && (obs[2] == 1'b0) && (lastDone >= 0)) begin
                total++;
                if ((rel - lastDone) !== 2) begin
                    bad++;
                    $display("[TB] FAIL b2b.gap rel=%0d got=%0d want=2", rel, rel - lastDone);
                end
            end
            prevBtn = obs[2];
            if (obs[0]) begin
                doneCnt++;
                lastDone = rel;
            end
            if (rel == 36) bus.start = 1'b0;
        end
        total++;
        if (doneCnt !== 6) begin bad++; $display("[TB] FAIL b2b.doneCnt got=%0d want=6", doneCnt); end
    endtask

    task automatic test_random();
        logic [2:0] obs;
        int doneCnt = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            obs = {bus.btn_n, bus.busy, bus.done};
            total++;
            if (obs !== expOut) begin
                bad++;
                $display("[TB] FAIL random.wave cyc=%0d got=%b want=%b", cyc, obs, expOut);
            end
            if (obs[0]) doneCnt++;
            bus.start = ($urandom_range(0, 3) == 0);
            bus.dur_ms = DUR_W'($urandom_range(0, 3));
            bus.repeat_n = REP_W'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 199) != 0);
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        total++;
        if (doneCnt <= 0) begin bad++; $display("[TB] FAIL random.doneSeen got=%0d want>0", doneCnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dur_ms = '0;
        bus.repeat_n = '0;
        test_reset();
        test_single_press();
        test_repeat();
        test_zero_fields();
        test_ignored_start();
        test_reset_mid_press();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule

// File: doc/btn_press_gen.md
Name: btn_press_gen

Overview:
Generates timed active-low button-press waveforms on an output line. It is the transmitter-side counterpart of the long-press detectors used on the Cyclone IV boards. Press duration, repeat count and inter-press gap are set per command. Used for on-board self-test of press detectors, and for driving the button input of a second board through a GPIO wire.

Parameters:
CLOCK_RATE_HZ, 50_000_000, input clock frequency. Must be a multiple of 1000.
GAP_MS, 100, released time between consecutive presses, in ms (≥1).
DUR_W, 16, width of the duration field, in ms.
REP_W, 4, width of the repeat-count field.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
start  input  1  command strobe; sampled high only while busy=0
dur_ms  input  DUR_W  press length in ms; latched on accepted start
repeat_n  input  REP_W  number of presses; latched on accepted start
btn_n  output  1  generated button line; 0 = pressed, 1 = released
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at the end of a command

Behaviour:
- Timing constant: TPM = CLOCK_RATE_HZ/1000 cycles per ms.
- Tick counter: internal ms counter wraps at TPM-1 and emits a tick. Cleared to 0 on every state entry, so each phase length is exact.
- Reset: rst_n=0 at a clk edge forces state IDLE, btn_n=1, busy=0, done=0, and all counters 0. This also applies mid-press: btn_n returns to 1 on that edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States:
  - IDLE: btn_n=1, busy=0.
  - PRESS: btn_n=0, busy=1.
  - GAP: btn_n=1, busy=1.
  - FIN: btn_n=1, busy=1, done=1 for exactly one cycle.
- IDLE transitions, when start=1 at edge k:
  - Latch dur_ms and repeat_n.
  - If either is 0: go to FIN. busy=1 and done=1 at k+1; no press is generated.
  - Otherwise: go to PRESS. btn_n=0 and busy=1 from k+1. The press counter is set to 1.
- PRESS holds for exactly dur_ms*TPM cycles. Then:
  - If press counter == repeat latch: go to FIN.
  - Otherwise: go to GAP.
- GAP holds for exactly GAP_MS*TPM cycles, then returns to PRESS and the press counter increments.
- FIN lasts one cycle, then IDLE. busy=0 from the following cycle; a new start is accepted that same cycle.
- There is no trailing gap after the last press.
- start while busy=1 or in FIN is ignored. Latched values are unaffected by input changes mid-command.
- Arithmetic:
  - Duration counter is DUR_W bits, counting ms ticks.
  - Press counter is REP_W bits.
  - Maximum dur_ms = 2^DUR_W-1 ms with no overflow. The tick counter width is clog2(TPM).
- Total command length for R≥1, D≥1: R*D*TPM + (R-1)*GAP_MS*TPM + 1 (FIN) cycles, measured from k+1.

Test Plan:
Bench uses CLOCK_RATE_HZ=4000 (TPM=4) and GAP_MS=2.
- Single press: start with dur_ms=3, repeat_n=1 at cycle 10 -> btn_n=0 for cycles 11–22 (12 cycles), done=1 at cycle 23 only, busy=1 for cycles 11–23, busy=0 at 24.
- Repeat: dur_ms=1, repeat_n=3 -> three 4-cycle lows separated by two 8-cycle highs, then done one cycle after the third press ends. Total busy = 29 cycles.
- Zero fields: dur_ms=0 (or repeat_n=0) -> btn_n stays 1; busy and done high for one cycle at k+1; back to IDLE at k+2.
- Ignored start and input changes: pulse start and change dur_ms/repeat_n mid-press -> waveform identical to the unperturbed run; no extra done pulse.
- Reset mid-press: rst_n=0 for 1 cycle at the 5th low cycle -> btn_n=1 on that edge; busy=0 and done=0 thereafter. A subsequent start produces a full-length press.
- Back-to-back: start held high continuously -> the next command is accepted in the cycle after done. btn_n falls 2 cycles after the done pulse, with no lost or double command.
